// File: rtl/double_ne_cmp.sv
// Registered IEEE-754 binary64 "not equal" comparator with one cycle of latency.
// NaN is never equal to anything, the two signed zeros are equal, and everything else compares by bit pattern.
module double_ne_cmp (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        z
);

   localparam int unsigned EXP_W  = 11;
   localparam int unsigned FRAC_W = 52;

   localparam logic [EXP_W-1:0]  EXP_ALL_ONES = '1;
   localparam logic [EXP_W-1:0]  EXP_ZERO     = '0;
   localparam logic [FRAC_W-1:0] FRAC_ZERO    = '0;

   logic [EXP_W-1:0]  a_exp;
   logic [EXP_W-1:0]  b_exp;
   logic [FRAC_W-1:0] a_frac;
   logic [FRAC_W-1:0] b_frac;

   logic a_nan;
   logic b_nan;
   logic a_zero;
   logic b_zero;
   logic any_nan;
   logic both_zero;
   logic bits_match;
   logic equal;
   logic ne_next;

   assign a_exp  = a[62:52];
   assign b_exp  = b[62:52];
   assign a_frac = a[51:0];
   assign b_frac = b[51:0];

   // Infinity (all-ones exponent, zero fraction) is deliberately not NaN, so +Inf == +Inf.
   assign a_nan  = (a_exp == EXP_ALL_ONES) && (a_frac != FRAC_ZERO);
   assign b_nan  = (b_exp == EXP_ALL_ONES) && (b_frac != FRAC_ZERO);

   // Sign is ignored for zero; subnormals are not flushed and stay distinct from zero.
   assign a_zero = (a_exp == EXP_ZERO) && (a_frac == FRAC_ZERO);
   assign b_zero = (b_exp == EXP_ZERO) && (b_frac == FRAC_ZERO);

   assign any_nan    = a_nan | b_nan;
   assign both_zero  = a_zero & b_zero;
   assign bits_match = (a == b);

   always_comb begin
      equal = 1'b0;
      if (any_nan) begin
         equal = 1'b0;
      end else if (both_zero) begin
         equal = 1'b1;
      end else begin
         equal = bits_match;
      end
   end

   assign ne_next = ~equal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z <= 1'b0;
      end else begin
         z <= ne_next;
      end
   end

endmodule

// File: tb/tb_double_ne_cmp.sv
// Directed and streaming bench for double_ne_cmp.
// Inputs change on the falling edge; z is sampled on the next falling edge.
module tb_double_ne_cmp;

   logic        clk;
   logic        rst_n;
   logic [63:0] a;
   logic [63:0] b;
   logic        z;

   int checks;
   int errors;

   logic [63:0] exp_q[$];

   double_ne_cmp dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .z     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: magnitude above the +Inf pattern is NaN; shifting out the sign detects either zero.
   function automatic logic ref_ne(input logic [63:0] x, input logic [63:0] y);
      logic [63:0] mx;
      logic [63:0] my;
      mx = x & 64'h7FFF_FFFF_FFFF_FFFF;
      my = y & 64'h7FFF_FFFF_FFFF_FFFF;
      if (mx > 64'h7FF0_0000_0000_0000 || my > 64'h7FF0_0000_0000_0000) return 1'b1;
      if ((x << 1) == 64'd0 && (y << 1) == 64'd0) return 1'b0;
      return (x != y);
   endfunction

   task automatic apply_pair(input logic [63:0] va, input logic [63:0] vb);
      @(negedge clk);
      a = va;
      b = vb;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a = 64'h3FF0_0000_0000_0000;
      b = 64'h4000_0000_0000_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (z !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: z=%b expected 0", i, z);
         end
      end
      rst_n = 1'b1;
      apply_pair(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_one_eq_one: z=%b expected 0", z);
      end
   endtask

   task automatic test_finite();
      apply_pair(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL finite_one_vs_two: z=%b expected 1", z);
      end
      apply_pair(64'hC009_21FB_5444_2D18, 64'hC009_21FB_5444_2D18);
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL finite_neg_pi_equal: z=%b expected 0", z);
      end
      apply_pair(64'hC009_21FB_5444_2D18, 64'h4009_21FB_5444_2D18);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL finite_pi_sign_differs: z=%b expected 1", z);
      end
   endtask

   task automatic test_zeros();
      apply_pair(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000);
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL zero_pos_vs_neg: z=%b expected 0", z);
      end
      apply_pair(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL zero_neg_vs_neg: z=%b expected 0", z);
      end
      apply_pair(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL zero_vs_min_subnormal: z=%b expected 1", z);
      end
      apply_pair(64'h0008_0000_0000_0000, 64'h0008_0000_0000_0000);
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL subnormal_equal: z=%b expected 0", z);
      end
   endtask

   task automatic test_nan();
      apply_pair(64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL nan_same_qnan: z=%b expected 1", z);
      end
      apply_pair(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL nan_snan_vs_one: z=%b expected 1", z);
      end
      apply_pair(64'h3FF0_0000_0000_0000, 64'hFFF8_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL nan_one_vs_neg_qnan: z=%b expected 1", z);
      end
      apply_pair(64'h7FF0_0000_0000_0001, 64'h7FF0_0000_0000_0001);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL nan_same_snan: z=%b expected 1", z);
      end
      apply_pair(64'h0000_0000_0000_0000, 64'h7FF8_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL nan_zero_vs_qnan: z=%b expected 1", z);
      end
   endtask

   task automatic test_inf();
      apply_pair(64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000);
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL inf_pos_vs_pos: z=%b expected 0", z);
      end
      apply_pair(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL inf_pos_vs_neg: z=%b expected 1", z);
      end
      apply_pair(64'h7FF0_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL inf_vs_max_finite: z=%b expected 1", z);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] specials[8];
      logic [63:0] va;
      logic [63:0] vb;
      specials[0] = 64'h0000_0000_0000_0000;
      specials[1] = 64'h8000_0000_0000_0000;
      specials[2] = 64'h7FF0_0000_0000_0000;
      specials[3] = 64'hFFF0_0000_0000_0000;
      specials[4] = 64'h7FF8_0000_0000_0000;
      specials[5] = 64'h7FF0_0000_0000_0001;
      specials[6] = 64'h0000_0000_0000_0001;
      specials[7] = 64'h3FF0_0000_0000_0000;
      exp_q.delete();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            checks++;
            if (z !== exp_q[0][0]) begin
               errors++;
               $display("FAIL stream_pair %0d: z=%b expected %b", i - 1, z, exp_q[0][0]);
            end
            void'(exp_q.pop_front());
         end
         va = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) va = specials[$urandom_range(0, 7)];
         case ($urandom_range(0, 3))
            0:       vb = va;
            1:       vb = va ^ 64'h8000_0000_0000_0000;
            2:       vb = specials[$urandom_range(0, 7)];
            default: vb = {$urandom, $urandom};
         endcase
         a = va;
         b = vb;
         exp_q.push_back({63'd0, ref_ne(va, vb)});
      end
      @(negedge clk);
      checks++;
      if (z !== exp_q[0][0]) begin
         errors++;
         $display("FAIL stream_last: z=%b expected %b", z, exp_q[0][0]);
      end
      void'(exp_q.pop_front());
   endtask

   task automatic test_mid_reset();
      apply_pair(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_pre: z=%b expected 1", z);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async_clear: z=%b expected 0", z);
      end
      @(posedge clk);
      #1;
      checks++;
      if (z !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_held: z=%b expected 0", z);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (z !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_first_result: z=%b expected 1", z);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      a      = '0;
      b      = '0;
      test_reset();
      test_finite();
      test_zeros();
      test_nan();
      test_inf();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
